// File: rtl/io_pkg.sv
// Shared constants and FSM state type for the I/O bus poll master.
package io_pkg;

  localparam logic [31:0] OFF_SWITCHES = 32'h0;
  localparam logic [31:0] OFF_LEDS     = 32'h4;
  localparam logic [31:0] OFF_SEG1     = 32'h8;
  localparam logic [31:0] OFF_SEG2     = 32'hC;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    REQ     = 3'd2,
    RD_SW   = 3'd3,
    WR_LED  = 3'd4,
    WR_SEG1 = 3'd5,
    WR_SEG2 = 3'd6,
    REL     = 3'd7
  } poll_state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-high 7-segment pattern (bit0 = seg a).
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/io_poll_master.sv
// Bus-master poller: reads switches periodically and on change updates LEDS, SEG1 (value) and SEG2 (change count).
module io_poll_master
  import io_pkg::*;
#(
  parameter int          POLL_CYCLES = 1000,
  parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        we,
  output logic [31:0] a,
  output logic [31:0] wd,
  output logic [2:0]  funct3,
  input  logic [31:0] rd,
  output logic        busy,
  output logic [7:0]  change_count
);

  localparam logic [31:0] WAIT_LOAD = 32'(POLL_CYCLES - 1);

  poll_state_t state, state_nxt;
  logic [31:0] wait_cnt, wait_cnt_nxt;
  logic [3:0]  sw_last, sw_last_nxt;
  logic        first_done, first_done_nxt;
  logic [7:0]  count_q, count_nxt;
  logic        we_q, we_nxt;
  logic [31:0] a_q, a_nxt;
  logic [31:0] wd_q, wd_nxt;
  logic        bus_req_q, bus_req_nxt;
  logic        busy_q, busy_nxt;
  logic [3:0]  hex_in;
  logic [6:0]  hex_seg;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd[31:4];

  // One decoder serves both display writes; its input follows the state being entered.
  assign hex_in = (state_nxt == WR_SEG2) ? count_nxt[3:0] : sw_last_nxt;

  hex_to_7seg u_hex (
    .hex (hex_in),
    .seg (hex_seg)
  );

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = WAIT_LOAD;
    sw_last_nxt    = sw_last;
    first_done_nxt = first_done;
    count_nxt      = count_q;
    case (state)
      IDLE: if (enable) state_nxt = WAIT;
      WAIT: begin
        if (!enable)              state_nxt = IDLE;
        else if (wait_cnt == '0)  state_nxt = REQ;
        else                      wait_cnt_nxt = wait_cnt - 32'd1;
      end
      REQ:  if (bus_gnt) state_nxt = RD_SW;
      RD_SW: begin
        if (bus_gnt) begin
          if ((rd[3:0] != sw_last) || !first_done) begin
            state_nxt      = WR_LED;
            if (first_done) count_nxt = count_q + 8'd1;
            first_done_nxt = 1'b1;
            sw_last_nxt    = rd[3:0];
          end else begin
            state_nxt = REL;
          end
        end
      end
      WR_LED:  if (bus_gnt) state_nxt = WR_SEG1;
      WR_SEG1: if (bus_gnt) state_nxt = WR_SEG2;
      WR_SEG2: if (bus_gnt) state_nxt = REL;
      REL:     state_nxt = enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered from the state being entered, so they decode the current state.
  always_comb begin
    we_nxt = 1'b0;
    a_nxt  = '0;
    wd_nxt = '0;
    case (state_nxt)
      RD_SW:   a_nxt = IO_BASE + OFF_SWITCHES;
      WR_LED:  begin we_nxt = 1'b1; a_nxt = IO_BASE + OFF_LEDS; wd_nxt = {28'b0, sw_last_nxt}; end
      WR_SEG1: begin we_nxt = 1'b1; a_nxt = IO_BASE + OFF_SEG1; wd_nxt = {25'b0, hex_seg}; end
      WR_SEG2: begin we_nxt = 1'b1; a_nxt = IO_BASE + OFF_SEG2; wd_nxt = {25'b0, hex_seg}; end
      default: ;
    endcase
    bus_req_nxt = (state_nxt == REQ) || (state_nxt == RD_SW) || (state_nxt == WR_LED) ||
                  (state_nxt == WR_SEG1) || (state_nxt == WR_SEG2);
    busy_nxt    = (state_nxt != IDLE) && (state_nxt != WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= WAIT_LOAD;
      sw_last    <= '0;
      first_done <= 1'b0;
      count_q    <= '0;
      we_q       <= 1'b0;
      a_q        <= '0;
      wd_q       <= '0;
      bus_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      sw_last    <= sw_last_nxt;
      first_done <= first_done_nxt;
      count_q    <= count_nxt;
      we_q       <= we_nxt;
      a_q        <= a_nxt;
      wd_q       <= wd_nxt;
      bus_req_q  <= bus_req_nxt;
      busy_q     <= busy_nxt;
    end
  end

  // Without a grant the bus is left quiet; the state holds so the access resumes intact.
  assign we           = we_q & bus_gnt;
  assign a            = bus_gnt ? a_q : 32'h0;
  assign wd           = wd_q;
  assign funct3       = F3_WORD;
  assign bus_req      = bus_req_q;
  assign busy         = busy_q;
  assign change_count = count_q;

endmodule

// File: doc/io_poll_master.md
# io_poll_master

Autonomous MMIO initiator that shares the I/O bus with the CPU and drives the `io` peripheral from the bus-master side. It periodically reads the switch register, and on every change it mirrors the value to the LEDs, shows it in hex on SEG1, and shows a running change counter on SEG2. It sits beside the core, behind a request/grant arbiter, and uses the same `we`/`a`/`wd`/`funct3`/`rd` bus signals that the core's data port uses.

## Interface
- `POLL_CYCLES`, default 1000: idle cycles between switch polls (must be at least 1).
- `IO_BASE`, default 32'h0000_1000: base address of the I/O block. Register offsets: SWITCHES +0x0, LEDS +0x4, SEG1 +0x8, SEG2 +0xC.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assertion, active-low.
- `enable`  in  1: polling is allowed while high.
- `bus_req`  out  1: request for ownership of the I/O bus.
- `bus_gnt`  in  1: the arbiter grants the bus; this block may drive `we`/`a` only while `bus_gnt` is high.
- `we`  out  1: write strobe to the peripheral.
- `a`  out  32: access address.
- `wd`  out  32: write data. Bits above the register width are zero.
- `funct3`  out  3: access size. Always 3'b010 (word).
- `rd`  in  32: combinational read data from the peripheral.
- `busy`  out  1: high in every state except IDLE and WAIT.
- `change_count`  out  8: number of detected switch changes. Wraps from 255 to 0.

## Operation
- FSM states: IDLE, WAIT, REQ, RD_SW, WR_LED, WR_SEG1, WR_SEG2, REL.
- IDLE → WAIT when `enable`=1.
- WAIT:
  - Down-counter loaded with POLL_CYCLES-1.
  - At 0, go to REQ.
  - If `enable`=0, return to IDLE and reload the counter.
- REQ: assert `bus_req`, hold it until `bus_gnt`=1, then go to RD_SW.
- RD_SW:
  - Drive `a`=IO_BASE+0x0 with `we`=0.
  - Sample `rd[3:0]` into `sw_now` at the clock edge.
  - If `sw_now`≠`sw_last`, or `first_done`=0, go to WR_LED; otherwise go to REL.
- On a detected change, increment `change_count`, except on the first forced update.
  - The increment happens in the RD_SW→WR_LED transition, so SEG2 shows the new count.
  - Then set `first_done`=1 and `sw_last`=`sw_now`.
- WR_LED: `a`=+0x4, `wd`={28'b0,`sw_last`}, `we`=1.
- WR_SEG1: `a`=+0x8, `wd`={25'b0, hex7(`sw_last`)}, `we`=1.
- WR_SEG2: `a`=+0xC, `wd`={25'b0, hex7(`change_count[3:0]`)}, `we`=1.
- REL: deassert `bus_req` for one cycle, then go to WAIT.
- hex7 encoding, active-high, bit0=seg a … bit6=seg g:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Grant loss: if `bus_gnt` falls while in RD_SW through WR_SEG2:
  - Force `we`=0 and `a`=0.
  - Hold the state, keeping `bus_req` high.
  - Resume the same access when the grant returns. No write is lost or duplicated.
- `enable` dropping mid-sequence: the sequence completes through REL, then the FSM goes to IDLE.

## Timing
- Reset values:
  - Outputs: `bus_req`=0, `we`=0, `a`=0, `wd`=0, `funct3`=3'b010, `busy`=0, `change_count`=0.
  - Internal: `sw_last`=0, `first_done`=0, FSM in IDLE.
- Reset mid-operation: all of the above take effect immediately and asynchronously. A write in flight is dropped.
- Bus outputs are registered-state decoded (Moore). `we` is high for exactly one cycle per write state while granted.
- Read latency: `rd` is sampled at the end of the RD_SW cycle.
- With a continuous grant:
  - Changed poll: REQ, RD_SW, WR_LED, WR_SEG1, WR_SEG2, REL = 6 cycles.
  - Unchanged poll: 3 cycles.
- Poll period: POLL_CYCLES cycles in WAIT, plus the sequence, plus any grant wait.
- Simultaneous `bus_gnt` rise and `enable` fall in REQ: the sequence proceeds.

## Structure
- Package `io_pkg`:
  - Register offset constants (SWITCHES, LEDS, SEG1, SEG2).
  - Funct3 constants (BYTE, HALF, WORD).
  - `typedef enum logic [2:0]` for the FSM states.
- Sub-module `hex_to_7seg`: combinational 4-bit to 7-bit decoder. It is reused for WR_SEG1 and WR_SEG2.

## Test plan
- Reset, then `enable`=1, `bus_gnt` tied high, switches=4'h5, POLL_CYCLES=4:
  - Writes LEDS=5, SEG1=0x6D, SEG2=0x3F.
  - `change_count`=0.
- Switches held at 5 across three polls: only SWITCHES reads occur, no writes, `change_count` stays 0.
- Switches 5→A: writes LEDS=A, SEG1=0x77, SEG2=0x06; `change_count`=1.
- `bus_gnt` dropped for 3 cycles during WR_SEG1:
  - `we`=0 for those cycles and `bus_req` stays high.
  - SEG1 is written exactly once after the grant returns.
- 256 alternating changes: `change_count` wraps to 0 and SEG2 is written with 0x3F.
- `rst_n` asserted during WR_LED: `we`/`bus_req` drop in the same cycle, `change_count`=0, and the first poll after reset forces a full update.
